// File: rtl/gl_matrix_stack.sv
// Modelview/projection matrix state with per-mode push/pop stacks.
// Optional sticky overflow/underflow flags: define GL_MATRIX_STACK_ERR_EN.
module gl_matrix_stack #(
   parameter int          MV_DEPTH   = 8,
   parameter int          PROJ_DEPTH = 2,
   parameter logic [31:0] ONE        = 32'h0001_0000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         matrix_mode_in,
   input  logic         push_en,
   input  logic         pop_en,
   input  logic         matrix_load_en,
   input  logic         matrix_load_id_en,
   input  logic         load_valid,
   input  logic [31:0]  load_row_in_0,
   input  logic [31:0]  load_row_in_1,
   input  logic [31:0]  load_row_in_2,
   input  logic [31:0]  load_row_in_3,
   output logic [511:0] mv_matrix_out,
   output logic [511:0] proj_matrix_out,
   output logic         stall,
   output logic         stack_overflow,
   output logic         stack_underflow
);

   localparam int MV_AW = $clog2(MV_DEPTH);
   localparam int PJ_AW = $clog2(PROJ_DEPTH);

   typedef logic [3:0][31:0]        row_t;
   typedef logic [3:0][3:0][31:0]   mat_t;
   typedef enum logic [1:0] {IDLE, LOAD, PUSH, POP} state_t;

   function automatic mat_t ident();
      mat_t m;
      m = '0;
      for (int i = 0; i < 4; i++) m[i][i] = ONE;
      return m;
   endfunction

   state_t           state;
   logic [1:0]       cnt;
   logic             op_mode;
   mat_t             mv_cur, pj_cur;
   logic [MV_AW:0]   mv_sp;
   logic [PJ_AW:0]   pj_sp;

   // Stack rows are addressed {sp, row}; contents are not reset.
   row_t mv_stk [MV_DEPTH*4];
   row_t pj_stk [PROJ_DEPTH*4];

   logic idle, sel_full, sel_empty;
   logic do_pop, do_push, do_load, do_lid;
   logic row_wr_en;
   row_t mv_rd, pj_rd, wr_row;

   assign idle      = (state == IDLE);
   assign stall     = !idle;
   assign sel_full  = matrix_mode_in ? (pj_sp == (PJ_AW+1)'(PROJ_DEPTH))
                                     : (mv_sp == (MV_AW+1)'(MV_DEPTH));
   assign sel_empty = matrix_mode_in ? (pj_sp == '0) : (mv_sp == '0);

   // Fixed priority pop > push > load > load_id; losers are simply dropped.
   assign do_pop  = idle && pop_en && !sel_empty;
   assign do_push = idle && !pop_en && push_en && !sel_full;
   assign do_load = idle && !pop_en && !push_en && matrix_load_en;
   assign do_lid  = idle && !pop_en && !push_en && !matrix_load_en && matrix_load_id_en;

   assign mv_rd     = mv_stk[{mv_sp[MV_AW-1:0], cnt}];
   assign pj_rd     = pj_stk[{pj_sp[PJ_AW-1:0], cnt}];
   assign row_wr_en = (state == POP) || ((state == LOAD) && load_valid);
   assign wr_row    = (state == POP) ? (op_mode ? pj_rd : mv_rd)
                                     : {load_row_in_3, load_row_in_2, load_row_in_1, load_row_in_0};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 2'd0;
         op_mode <= 1'b0;
         mv_sp   <= '0;
         pj_sp   <= '0;
         mv_cur  <= ident();
         pj_cur  <= ident();
      end else begin
         if (row_wr_en) begin
            if (op_mode) pj_cur[cnt] <= wr_row;
            else         mv_cur[cnt] <= wr_row;
         end
         case (state)
            IDLE: begin
               cnt <= 2'd0;
               if (do_pop) begin
                  // sp drops at accept so the copy reads the top entry
                  op_mode <= matrix_mode_in;
                  state   <= POP;
                  if (matrix_mode_in) pj_sp <= pj_sp - 1'b1;
                  else                mv_sp <= mv_sp - 1'b1;
               end else if (do_push) begin
                  op_mode <= matrix_mode_in;
                  state   <= PUSH;
               end else if (do_load) begin
                  op_mode <= matrix_mode_in;
                  state   <= LOAD;
               end else if (do_lid) begin
                  if (matrix_mode_in) pj_cur <= ident();
                  else                mv_cur <= ident();
               end
            end
            LOAD: begin
               if (load_valid) begin
                  cnt <= cnt + 2'd1;
                  if (cnt == 2'd3) state <= IDLE;
               end
            end
            PUSH: begin
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state <= IDLE;
                  if (op_mode) pj_sp <= pj_sp + 1'b1;
                  else         mv_sp <= mv_sp + 1'b1;
               end
            end
            POP: begin
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == PUSH) begin
         if (op_mode) pj_stk[{pj_sp[PJ_AW-1:0], cnt}] <= pj_cur[cnt];
         else         mv_stk[{mv_sp[MV_AW-1:0], cnt}] <= mv_cur[cnt];
      end
   end

   assign mv_matrix_out   = mv_cur;
   assign proj_matrix_out = pj_cur;

`ifdef GL_MATRIX_STACK_ERR_EN
   logic rej_push, rej_pop;
   assign rej_pop  = idle && pop_en && sel_empty;
   assign rej_push = idle && !pop_en && push_en && sel_full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stack_overflow  <= 1'b0;
         stack_underflow <= 1'b0;
      end else begin
         if (rej_push) stack_overflow  <= 1'b1;
         if (rej_pop)  stack_underflow <= 1'b1;
      end
   end
`else
   assign stack_overflow  = 1'b0;
   assign stack_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_gl_matrix_stack.sv
// Directed bench for gl_matrix_stack: per-cycle compare against a matrix/queue
// model plus literal checks of latencies, element values and error flags.
module tb_gl_matrix_stack;
   localparam int          MVD = 8;
   localparam int          PJD = 2;
   localparam logic [31:0] ONE = 32'h0001_0000;
`ifdef GL_MATRIX_STACK_ERR_EN
   localparam logic EXP_FLAG = 1'b1;
`else
   localparam logic EXP_FLAG = 1'b0;
`endif

   logic clk = 1'b0, reset = 1'b0;
   logic matrix_mode_in = 0, push_en = 0, pop_en = 0, matrix_load_en = 0;
   logic matrix_load_id_en = 0, load_valid = 0;
   logic [31:0] load_row_in_0 = 0, load_row_in_1 = 0, load_row_in_2 = 0, load_row_in_3 = 0;
   logic [511:0] mv_matrix_out, proj_matrix_out;
   logic stall, stack_overflow, stack_underflow;

   always #5 clk = ~clk;

   gl_matrix_stack #(.MV_DEPTH(MVD), .PROJ_DEPTH(PJD), .ONE(ONE)) dut (
      .clk(clk), .reset(reset), .matrix_mode_in(matrix_mode_in),
      .push_en(push_en), .pop_en(pop_en), .matrix_load_en(matrix_load_en),
      .matrix_load_id_en(matrix_load_id_en), .load_valid(load_valid),
      .load_row_in_0(load_row_in_0), .load_row_in_1(load_row_in_1),
      .load_row_in_2(load_row_in_2), .load_row_in_3(load_row_in_3),
      .mv_matrix_out(mv_matrix_out), .proj_matrix_out(proj_matrix_out),
      .stall(stall), .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
   );

   int tests = 0, fails = 0;
   int stall_cnt = 0;
   bit chk_en = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] ident_m();
      logic [511:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) m[(i*4+i)*32 +: 32] = ONE;
      return m;
   endfunction

   function automatic logic [511:0] mat_seq(input int base);
      logic [511:0] m;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) m[(r*4+c)*32 +: 32] = 32'(base + r*4 + c);
      return m;
   endfunction

   function automatic logic [31:0] elem(input logic [511:0] m, input int r, input int c);
      return m[(r*4+c)*32 +: 32];
   endfunction

   // Model: current matrices, stacks as queues, and a pending op with a row index.
   logic [511:0] m_cur [2];
   logic [511:0] m_q0 [$];
   logic [511:0] m_q1 [$];
   logic [511:0] m_src;
   int m_kind = 0, m_row = 0, m_mode = 0;   // kind: 0 none, 1 load, 2 push, 3 pop
   logic m_ovf = 0, m_unf = 0;

   always @(posedge clk or posedge reset) begin
      int md, sz;
      if (reset) begin
         m_cur[0] = ident_m();
         m_cur[1] = ident_m();
         m_q0.delete();
         m_q1.delete();
         m_kind = 0; m_row = 0; m_ovf = 0; m_unf = 0;
      end else if (m_kind == 0) begin
         md = int'(matrix_mode_in);
         sz = md ? m_q1.size() : m_q0.size();
         if (pop_en) begin
            if (sz == 0) m_unf = 1;
            else begin
               m_src  = md ? m_q1.pop_back() : m_q0.pop_back();
               m_kind = 3; m_mode = md; m_row = 0;
            end
         end else if (push_en) begin
            if (sz == (md ? PJD : MVD)) m_ovf = 1;
            else begin m_kind = 2; m_mode = md; m_row = 0; end
         end else if (matrix_load_en) begin
            m_kind = 1; m_mode = md; m_row = 0;
         end else if (matrix_load_id_en) begin
            m_cur[md] = ident_m();
         end
      end else begin
         if (m_kind == 1 && load_valid) begin
            m_cur[m_mode][m_row*128 +: 128] = {load_row_in_3, load_row_in_2, load_row_in_1, load_row_in_0};
            m_row++;
         end else if (m_kind == 3) begin
            m_cur[m_mode][m_row*128 +: 128] = m_src[m_row*128 +: 128];
            m_row++;
         end else if (m_kind == 2) begin
            m_row++;
            if (m_row == 4) begin
               if (m_mode == 1) m_q1.push_back(m_cur[1]);
               else             m_q0.push_back(m_cur[0]);
            end
         end
         if (m_row == 4) m_kind = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_stall", stall, m_kind != 0);
         check("cyc_mv", mv_matrix_out, m_cur[0]);
         check("cyc_proj", proj_matrix_out, m_cur[1]);
         check("cyc_ovf", stack_overflow, m_ovf & EXP_FLAG);
         check("cyc_unf", stack_underflow, m_unf & EXP_FLAG);
      end
   end

   always @(negedge clk) if (stall === 1'b1) stall_cnt++;

   task automatic wait_idle();
      int n;
      n = 0;
      while (stall !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         tests++; fails++;
         $display("FAIL wait_idle: stall still %b after %0d cycles, want 0", stall, n);
      end
   endtask

   task automatic cmd(input logic p, input logic u, input logic l, input logic i, input logic md);
      @(negedge clk);
      pop_en = p; push_en = u; matrix_load_en = l; matrix_load_id_en = i;
      matrix_mode_in = md; stall_cnt = 0;
      @(negedge clk);
      pop_en = 0; push_en = 0; matrix_load_en = 0; matrix_load_id_en = 0;
      matrix_mode_in = ~md;
      wait_idle();
   endtask

   // gap >= 0 holds load_valid low for one cycle before that row
   task automatic load_mat(input logic md, input int base, input int gap);
      logic [511:0] m;
      m = mat_seq(base);
      @(negedge clk);
      matrix_load_en = 1; matrix_mode_in = md; stall_cnt = 0;
      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         matrix_load_en = 0; matrix_mode_in = ~md;
         if (r == gap) begin
            load_valid = 0;
            @(negedge clk);
         end
         load_valid = 1;
         {load_row_in_3, load_row_in_2, load_row_in_1, load_row_in_0} = m[r*128 +: 128];
      end
      @(negedge clk);
      load_valid = 0;
      wait_idle();
   endtask

   initial begin
      logic [511:0] mat_m;
      mat_m = mat_seq(1);
      #1 reset = 1;
      repeat (2) @(negedge clk);
      check("rst_stall", stall, 1'b0);
      check("rst_mv00", elem(mv_matrix_out, 0, 0), 32'h0001_0000);
      check("rst_mv01", elem(mv_matrix_out, 0, 1), 32'h0);
      check("rst_proj", proj_matrix_out, ident_m());
      reset = 0;
      chk_en = 1;

      // LOAD modelview with one idle beat between rows 1 and 2
      load_mat(1'b0, 1, 2);
      check("load_stall_cycles", stall_cnt, 5);
      check("load_mv23", elem(mv_matrix_out, 2, 3), 32'd12);
      check("load_mv_full", mv_matrix_out, mat_m);
      check("load_proj_unchanged", proj_matrix_out, ident_m());

      // push, load_id, pop restores M
      cmd(0, 1, 0, 0, 0);
      check("push_stall_cycles", stall_cnt, 4);
      cmd(0, 0, 0, 1, 0);
      check("lid_stall_cycles", stall_cnt, 0);
      check("lid_mv", mv_matrix_out, ident_m());
      cmd(1, 0, 0, 0, 0);
      check("pop_stall_cycles", stall_cnt, 4);
      check("pop_mv_restored", mv_matrix_out, mat_m);

      // projection overflow on the third push
      load_mat(1'b1, 100, -1);
      cmd(0, 1, 0, 0, 1);
      load_mat(1'b1, 200, -1);
      cmd(0, 1, 0, 0, 1);
      check("proj_push2_stall", stall_cnt, 4);
      cmd(0, 1, 0, 0, 1);
      check("proj_push3_stall", stall_cnt, 0);
      check("proj_overflow", stack_overflow, EXP_FLAG);
      cmd(0, 0, 0, 1, 1);
      cmd(1, 0, 0, 0, 1);
      check("proj_top_is_2nd", proj_matrix_out, mat_seq(200));
      check("proj_top_elem00", elem(proj_matrix_out, 0, 0), 32'd200);

      // modelview underflow
      cmd(1, 0, 0, 0, 0);
      check("unf_stall", stall_cnt, 0);
      check("unf_mv_unchanged", mv_matrix_out, mat_m);
      check("underflow", stack_underflow, EXP_FLAG);

      // pop wins over push and load with sp=1
      cmd(0, 1, 0, 0, 0);
      cmd(0, 0, 0, 1, 0);
      cmd(1, 1, 1, 0, 0);
      check("prio_stall_cycles", stall_cnt, 4);
      check("prio_mv_popped", mv_matrix_out, mat_m);
      cmd(1, 0, 0, 0, 0);
      check("prio_push_dropped", stall_cnt, 0);

      // reset in the middle of a load, after two rows
      @(negedge clk);
      matrix_load_en = 1; matrix_mode_in = 0;
      @(negedge clk);
      matrix_load_en = 0; load_valid = 1;
      {load_row_in_3, load_row_in_2, load_row_in_1, load_row_in_0} = {32'd4, 32'd3, 32'd2, 32'd1};
      @(negedge clk);
      {load_row_in_3, load_row_in_2, load_row_in_1, load_row_in_0} = {32'd8, 32'd7, 32'd6, 32'd5};
      @(negedge clk);
      load_valid = 0;
      check("midload_stall_before_rst", stall, 1'b1);
      #2 reset = 1;
      #1;
      check("rst_mid_stall", stall, 1'b0);
      check("rst_mid_mv00", elem(mv_matrix_out, 0, 0), 32'h0001_0000);
      check("rst_mid_mv01", elem(mv_matrix_out, 0, 1), 32'h0);
      check("rst_mid_proj", proj_matrix_out, ident_m());
      check("rst_mid_ovf", stack_overflow, 1'b0);
      @(negedge clk);
      reset = 0;
      cmd(1, 0, 0, 0, 1);
      check("rst_proj_sp0", stall_cnt, 0);
      cmd(1, 0, 0, 0, 0);
      check("rst_mv_sp0", stall_cnt, 0);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
